rom_fp_scan: RTL and testbench
==============================

Name: rom_fp_scan

Overview:
- Sequencer that sits directly downstream of the 8-entry, 32-bit IEEE-754 single-precision constant ROM (3-bit addr, OE, tri-stated data out).
- Drives the ROM address and OE, captures each word, and streams it out over a valid/ready interface.
- Also tracks running float max/min and a NaN flag over the scanned window.
- Feeds the FP datapath, which consumes the constants one at a time.

Parameters:
- AW, 3, ROM address width; depth is 2**AW, and addresses wrap modulo the depth.
- DW, 32, data width; fixed IEEE-754 single-precision layout (1 sign, 8 exponent, 23 mantissa).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  AW  first ROM address of the scan; captured on start
- count  in  AW+1  number of words to scan, 1..2**AW; captured on start; 0 is treated as 2**AW
- rom_addr  out  AW  address to ROM
- rom_oe  out  1  ROM output enable
- rom_data  in  DW  ROM data; may be Z when rom_oe=0
- out_data  out  DW  captured word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accept
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the scan completes
- max_val  out  DW  largest non-NaN value of the last scan
- min_val  out  DW  smallest non-NaN value of the last scan
- stats_valid  out  1  at least one non-NaN word was seen in the last completed scan
- nan_seen  out  1  at least one NaN was seen in the last completed scan

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state=IDLE.
  - rom_addr=0, rom_oe=0, out_data=0, out_valid=0, busy=0, done=0.
  - max_val=0, min_val=0, stats_valid=0, nan_seen=0.
- Reset asserted mid-scan aborts immediately: no done pulse, and statistics are cleared.
- FSM states: IDLE, DRIVE, CAPTURE, SEND, DONE.
- IDLE:
  - On start=1: latch base into rom_addr and count into the remaining counter.
  - Clear the working max/min/flags, then go to DRIVE.
  - start in any other state is ignored and is not queued.
- DRIVE: rom_oe=1, rom_addr held. Next state is CAPTURE; this cycle is the ROM settle cycle.
- CAPTURE:
  - rom_oe=1.
  - At the clock edge: out_data<=rom_data, update the working stats, state<=SEND.
- SEND:
  - rom_oe=0 and out_valid=1. out_data is held stable until out_valid&&out_ready.
  - On handshake with remaining>1: decrement remaining, rom_addr<=rom_addr+1 (wraps 7->0), state<=DRIVE.
  - On handshake with remaining==1: state<=DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Copy the working stats to max_val/min_val/stats_valid/nan_seen. These outputs hold until the next DONE or reset.
  - Next state is IDLE.
- Latency and throughput:
  - If start is sampled at edge k, out_valid is 1 after edge k+2.
  - Maximum throughput is one word per 3 cycles (DRIVE, CAPTURE, SEND with out_ready=1).
  - Backpressure stalls only in SEND.
- rom_oe is 1 only in DRIVE and CAPTURE. rom_data is never sampled in any other state, so a Z input is don't-care there.
- Float compare rules:
  - NaN is exponent=FF with mantissa!=0. It sets the working NaN flag and is excluded from max/min.
  - -0 (0x80000000) is canonicalised to +0 for the compare only. out_data is unmodified.
  - Ordering key: sign=1 -> ~x; sign=0 -> x^0x80000000. Compare keys unsigned; ±Inf order naturally.
  - The first non-NaN word of the scan initialises both working max and min.
  - On equal keys, the stored value is retained.
- If every scanned word is NaN: max_val=min_val=0, stats_valid=0, nan_seen=1.

Test Plan:
- Full scan with the production ROM image, base=0, count=8, out_ready=1:
  - Words stream in address order 0..7: 0986ab68, 10385ba9, 3f800000, 3e800000, 40400000, 41200000, 3ea00000, 3f600000.
  - done fires one cycle after the last handshake; max_val=41200000, min_val=0986ab68, stats_valid=1, nan_seen=0.
  - Total from start to done is 25 cycles.
- Wrap and count: base=6, count=4 -> addresses 6,7,0,1; max_val=3f600000, min_val=0986ab68.
- Backpressure: hold out_ready=0 for 5 cycles on the word at addr 2:
  - out_data stays 3f800000 with out_valid=1.
  - rom_oe stays 0 and rom_addr stays 2 during the stall.
  - No word is dropped or duplicated.
- Stub ROM {bf800000 (-1.0), 80000000 (-0), 7fc00000 (NaN), 00000000}, count=4 -> max_val=00000000 (the first zero, retained), min_val=bf800000, nan_seen=1, stats_valid=1.
- All-NaN stub with count=2 -> stats_valid=0, nan_seen=1, max_val=min_val=0. Also pulse start during SEND: it is ignored and no second scan runs.
- Reset mid-scan: assert rst_n=0 during CAPTURE of the 3rd word:
  - All outputs go to 0 immediately and no done pulse occurs.
  - After release, a new start scans correctly.

Source files
------------

// File: rtl/rom_fp_scan.sv
`default_nettype none
// ============================================================================
// Module      : rom_fp_scan
// Description : Sequencer placed downstream of a small IEEE-754
//               single-precision constant ROM. For each word it drives the
//               address with OE asserted, allows one settle cycle, then
//               captures the word and offers it on a valid/ready stream.
//               While scanning it tracks the running float max/min
//               (NaNs excluded) and whether any NaN was seen. When the scan
//               completes it pulses done and publishes those results.
// Ports       :
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   start_i         - one-cycle scan request (sampled only when idle)
//   base_i          - first ROM address of the scan
//   count_i         - number of words to scan (0 means 2**AW)
//   rom_addr_o      - ROM address
//   rom_oe_o        - ROM output enable
//   rom_data_i      - ROM data (may be Z while rom_oe_o is low)
//   out_data_o      - captured word
//   out_valid_o     - out_data_o valid
//   out_ready_i     - consumer accept
//   busy_o          - scan in progress
//   done_o          - one-cycle completion pulse
//   max_val_o       - largest non-NaN value of the last scan
//   min_val_o       - smallest non-NaN value of the last scan
//   stats_valid_o   - last scan contained at least one non-NaN word
//   nan_seen_o      - last scan contained at least one NaN
// Revision    : 1.0 - initial release
// ============================================================================
module rom_fp_scan #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   count_i,
    output logic [AW-1:0] rom_addr_o,
    output logic          rom_oe_o,
    input  logic [DW-1:0] rom_data_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] max_val_o,
    output logic [DW-1:0] min_val_o,
    output logic          stats_valid_o,
    output logic          nan_seen_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [AW:0]   c_rem_one  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   c_rem_full = c_rem_one << AW;
    localparam logic [AW-1:0] c_addr_one = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] c_neg_zero = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] c_sign_bit = {1'b1, {(DW-1){1'b0}}};

    // Maps a float onto an unsigned key whose integer order matches the
    // numeric order of the float (negatives reversed, positives lifted).
    function automatic logic [DW-1:0] fp_key(input logic [DW-1:0] x);
        fp_key = x[DW-1] ? ~x : (x ^ c_sign_bit);
    endfunction

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] wmax_q, wmax_d;
    logic [DW-1:0] wmin_q, wmin_d;
    logic          whave_q, whave_d;
    logic          wnan_q, wnan_d;
    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] min_q, min_d;
    logic          sv_q, sv_d;
    logic          ns_q, ns_d;

    logic          w_nan;
    logic [DW-1:0] w_canon;
    logic [DW-1:0] w_key_new;

    assign w_nan     = (rom_data_i[30:23] == 8'hFF) && (rom_data_i[22:0] != 23'd0);
    // -0 is folded to +0 so both zeros compare equal; the stored stats
    // therefore never contain -0, while out_data keeps the raw word.
    assign w_canon   = (rom_data_i == c_neg_zero) ? '0 : rom_data_i;
    assign w_key_new = fp_key(w_canon);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        wmax_d  = wmax_q;
        wmin_d  = wmin_q;
        whave_d = whave_q;
        wnan_d  = wnan_q;
        max_d   = max_q;
        min_d   = min_q;
        sv_d    = sv_q;
        ns_d    = ns_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = base_i;
                    rem_d   = (count_i == '0) ? c_rem_full : count_i;
                    wmax_d  = '0;
                    wmin_d  = '0;
                    whave_d = 1'b0;
                    wnan_d  = 1'b0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d = rom_data_i;
                if (w_nan) begin
                    wnan_d = 1'b1;
                end else if (!whave_q) begin
                    wmax_d  = w_canon;
                    wmin_d  = w_canon;
                    whave_d = 1'b1;
                end else begin
                    // Strict compares: on a tie the earlier word is kept.
                    if (w_key_new > fp_key(wmax_q)) wmax_d = w_canon;
                    if (w_key_new < fp_key(wmin_q)) wmin_d = w_canon;
                end
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready_i) begin
                    if (rem_q > c_rem_one) begin
                        rem_d   = rem_q - c_rem_one;
                        addr_d  = addr_q + c_addr_one;
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Working max/min are still zero when every word was NaN.
                max_d   = wmax_q;
                min_d   = wmin_q;
                sv_d    = whave_q;
                ns_d    = wnan_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            wmax_q  <= '0;
            wmin_q  <= '0;
            whave_q <= 1'b0;
            wnan_q  <= 1'b0;
            max_q   <= '0;
            min_q   <= '0;
            sv_q    <= 1'b0;
            ns_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            wmax_q  <= wmax_d;
            wmin_q  <= wmin_d;
            whave_q <= whave_d;
            wnan_q  <= wnan_d;
            max_q   <= max_d;
            min_q   <= min_d;
            sv_q    <= sv_d;
            ns_q    <= ns_d;
        end
    end

    // Control outputs are pure decodes of the state register.
    assign rom_oe_o      = (state_q == S_DRIVE) || (state_q == S_CAPTURE);
    assign out_valid_o   = (state_q == S_SEND);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign rom_addr_o    = addr_q;
    assign out_data_o    = data_q;
    assign max_val_o     = max_q;
    assign min_val_o     = min_q;
    assign stats_valid_o = sv_q;
    assign nan_seen_o    = ns_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_fp_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_fp_scan
// Description : Self-checking bench for rom_fp_scan with a behavioural
//               tri-state ROM and a float-value reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_fp_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  base;
    logic [3:0]  count;
    logic [2:0]  rom_addr;
    logic        rom_oe;
    logic [31:0] rom_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [31:0] max_val;
    logic [31:0] min_val;
    logic        stats_valid;
    logic        nan_seen;

    logic [31:0] rom_mem [8];

    always #5 clk = ~clk;

    assign rom_data = rom_oe ? rom_mem[rom_addr] : 32'hzzzz_zzzz;

    rom_fp_scan #(.AW(3), .DW(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .base_i        (base),
        .count_i       (count),
        .rom_addr_o    (rom_addr),
        .rom_oe_o      (rom_oe),
        .rom_data_i    (rom_data),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .busy_o        (busy),
        .done_o        (done),
        .max_val_o     (max_val),
        .min_val_o     (min_val),
        .stats_valid_o (stats_valid),
        .nan_seen_o    (nan_seen)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] got_q [$];
    int          done_cyc;
    int          first_valid_cyc;
    int          oe_viol;
    int          stall_bad;
    bit          stalled;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: floats ordered by their signed real value.
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic longint fval(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    task automatic run_scan(input logic [2:0] b, input logic [3:0] c, input bit rnd,
                            input int stall_addr, input bit poke);
        int cyc;
        int stall_left;
        bit poked;
        logic [31:0] held;
        got_q.delete();
        done_cyc = -1; first_valid_cyc = -1; oe_viol = 0; stall_bad = 0;
        stalled = 0; stall_left = 0; poked = 0; held = '0;
        @(posedge clk); #1;
        start = 1'b1; base = b; count = c; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base = 3'($urandom); count = 4'($urandom);
        cyc = 0;
        while (cyc < 400) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (out_valid && rom_oe) oe_viol++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && poke && !poked) begin
                start = 1'b1; base = 3'd5; count = 4'd3; poked = 1;
            end else begin
                start = 1'b0;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                if (out_data !== held || !out_valid || rom_oe || rom_addr !== 3'(stall_addr))
                    stall_bad++;
            end else if (out_valid && stall_addr >= 0 && !stalled && rom_addr == 3'(stall_addr)) begin
                stalled = 1; stall_left = 4; held = out_data; out_ready = 1'b0;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic verify(input string name, input logic [2:0] b, input logic [3:0] c);
        int n;
        logic [31:0] w, cw, mx, mn;
        bit have, ns;
        n = (c == 0) ? 8 : int'(c);
        have = 0; ns = 0; mx = '0; mn = '0;
        check({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({name, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
        check({name, "_oe_while_valid"}, oe_viol, 0);
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            w = rom_mem[(int'(b) + i) % 8];
            if (i < got_q.size()) check($sformatf("%s_word%0d", name, i), got_q[i], w);
            if (is_nan(w)) begin
                ns = 1;
            end else begin
                cw = (w == 32'h8000_0000) ? 32'h0 : w;
                if (!have) begin
                    mx = cw; mn = cw; have = 1;
                end else begin
                    if (fval(cw) > fval(mx)) mx = cw;
                    if (fval(cw) < fval(mn)) mn = cw;
                end
            end
        end
        check({name, "_max"}, max_val, mx);
        check({name, "_min"}, min_val, mn);
        check({name, "_stats_valid"}, 32'(stats_valid), 32'(have));
        check({name, "_nan_seen"}, 32'(nan_seen), 32'(ns));
    endtask

    task automatic load_production();
        rom_mem[0] = 32'h0986ab68; rom_mem[1] = 32'h10385ba9;
        rom_mem[2] = 32'h3f800000; rom_mem[3] = 32'h3e800000;
        rom_mem[4] = 32'h40400000; rom_mem[5] = 32'h41200000;
        rom_mem[6] = 32'h3ea00000; rom_mem[7] = 32'h3f600000;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; count = '0; out_ready = 1'b1;
        load_production();
        #1;
        check("rst_async_addr", {29'd0, rom_addr}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {26'd0, rom_oe, out_valid, busy, done, stats_valid, nan_seen}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_max", max_val, 32'd0);
        check("rst_min", min_val, 32'd0);
        rst_n = 1'b1;

        // Full production scan with fixed timing.
        run_scan(3'd0, 4'd8, 0, -1, 0);
        check("prod_first_valid_cyc", first_valid_cyc, 2);
        check("prod_done_cyc", done_cyc, 24);
        check("prod_max_const", max_val, 32'h41200000);
        check("prod_min_const", min_val, 32'h0986ab68);
        verify("prod", 3'd0, 4'd8);

        // Address wrap.
        run_scan(3'd6, 4'd4, 0, -1, 0);
        check("wrap_max_const", max_val, 32'h3f600000);
        verify("wrap", 3'd6, 4'd4);

        // Backpressure on the word at address 2.
        run_scan(3'd0, 4'd8, 0, 2, 0);
        check("bp_stalled", 32'(stalled), 32'd1);
        check("bp_hold_bad", stall_bad, 0);
        verify("bp", 3'd0, 4'd8);

        // Signed zero, negative and NaN handling.
        rom_mem[0] = 32'hbf800000; rom_mem[1] = 32'h80000000;
        rom_mem[2] = 32'h7fc00000; rom_mem[3] = 32'h00000000;
        run_scan(3'd0, 4'd4, 0, -1, 0);
        check("stub_max_const", max_val, 32'h00000000);
        check("stub_min_const", min_val, 32'hbf800000);
        verify("stub", 3'd0, 4'd4);

        // All-NaN scan, with a start pulse during SEND that must be ignored.
        rom_mem[0] = 32'h7fc00000; rom_mem[1] = 32'hffffffff;
        run_scan(3'd0, 4'd2, 0, -1, 1);
        verify("allnan", 3'd0, 4'd2);
        repeat (6) @(posedge clk);
        #1;
        check("allnan_no_second_scan", {31'd0, busy}, 32'd0);

        // Reset during CAPTURE of the third word.
        load_production();
        run_scan(3'd0, 4'd8, 0, -1, 0);
        @(posedge clk); #1;
        start = 1'b1; base = 3'd0; count = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("rstmid_in_capture", {28'd0, rom_addr, rom_oe}, {28'd0, 3'd2, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_ctrl", {26'd0, rom_oe, out_valid, busy, done, stats_valid, nan_seen}, 32'd0);
        check("rstmid_addr_data", {29'd0, rom_addr} | out_data, 32'd0);
        check("rstmid_stats", max_val | min_val, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_no_done", {30'd0, done, busy}, 32'd0);
        run_scan(3'd3, 4'd5, 0, -1, 0);
        verify("post_rst", 3'd3, 4'd5);

        // Randomized scans with random backpressure.
        for (int t = 0; t < 15; t++) begin
            for (int a = 0; a < 8; a++) begin
                case ($urandom_range(0, 5))
                    0: rom_mem[a] = {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7fffff))};
                    1: rom_mem[a] = 32'h80000000;
                    2: rom_mem[a] = 32'h00000000;
                    3: rom_mem[a] = {1'($urandom), 31'h7f800000};
                    default: rom_mem[a] = $urandom;
                endcase
            end
            begin
                logic [2:0] rb;
                logic [3:0] rc;
                rb = 3'($urandom);
                rc = 4'($urandom_range(0, 8));
                run_scan(rb, rc, 1, -1, 0);
                verify($sformatf("rand%0d", t), rb, rc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
